keypad_scan_ctrl: RTL and testbench

//   Sequences the 5x4 matrix keypad: drives one K_ROW line low at a time, samples
//   K_COL, debounces the full 20-key map across whole scans and reports each new
//   key press as a code through a valid/ack handshake.

---
 rtl/keypad_scan_ctrl.sv | 169 ++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner for a 5x4 keypad.
// Drives one active-low row at a time, samples the active-low columns after a
// settle time, debounces the whole 20-key map over consecutive full scans and
// hands out each newly pressed key as a code through a valid/ack slot.
module keypad_scan_ctrl #(
   parameter int unsigned SETTLE_CYC     = 1000,
   parameter int unsigned DEBOUNCE_SCANS = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        scan_en,
   input  logic [3:0]  K_COL,
   output logic [4:0]  K_ROW,
   output logic [19:0] key_map,
   output logic        key_valid,
   output logic [4:0]  key_code,
   input  logic        key_ack,
   output logic        scan_done
);

   localparam int unsigned SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int unsigned STABLE_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
   localparam logic [STABLE_W-1:0] STABLE_MAX  = STABLE_W'(DEBOUNCE_SCANS);
   localparam logic [STABLE_W-1:0] STABLE_ONE  = STABLE_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_COMPARE
   } state_t;

   state_t              state_q,  state_d;
   logic [2:0]          row_q,    row_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic [STABLE_W-1:0] stable_q, stable_d;
   logic [19:0]         snap_q,   snap_d;
   logic [19:0]         prev_q,   prev_d;
   logic [19:0]         map_q,    map_d;
   logic [19:0]         pend_q,   pend_d;
   logic [4:0]          k_row_q,  k_row_d;
   logic                valid_q,  valid_d;
   logic [4:0]          code_q,   code_d;
   logic                done_q,   done_d;

   logic [19:0]         new_press;
   logic [19:0]         low_mask;
   logic [4:0]          low_idx;

   // Scan sequencer: row stepping, settle timing, column sampling and debounce.
   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      settle_d  = settle_q;
      snap_d    = snap_q;
      prev_d    = prev_q;
      stable_d  = stable_q;
      map_d     = map_q;
      new_press = '0;
      case (state_q)
         ST_IDLE: begin
            if (scan_en) begin
               state_d  = ST_DRIVE;
               row_d    = '0;
               settle_d = '0;
            end
         end
         ST_DRIVE: begin
            // scan_en is not looked at here: a started scan always runs to COMPARE
            if (settle_q == SETTLE_LAST) begin
               for (int unsigned r = 0; r < 5; r++) begin
                  if (row_q == 3'(r)) snap_d[r*4 +: 4] = ~K_COL;
               end
               settle_d = '0;
               if (row_q == 3'd4) state_d = ST_COMPARE;
               else               row_d   = row_q + 3'd1;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         ST_COMPARE: begin
            if (snap_q == prev_q) begin
               if (stable_q != STABLE_MAX) stable_d = stable_q + 1'b1;
            end else begin
               stable_d = STABLE_ONE;
            end
            prev_d = snap_q;
            if ((stable_d == STABLE_MAX) && (snap_q != map_q)) begin
               new_press = snap_q & ~map_q;
               map_d     = snap_q;
            end
            if (scan_en) begin
               state_d  = ST_DRIVE;
               row_d    = '0;
               settle_d = '0;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Row drive and scan_done are derived from the next state so the registered pins track the state.
   always_comb begin
      k_row_d = '1;
      if (state_d == ST_DRIVE) k_row_d = ~(5'b00001 << row_d);
      done_d  = (state_d == ST_COMPARE);
   end

   // Event slot: one press code at a time, lowest pending code first.
   always_comb begin
      valid_d  = valid_q;
      code_d   = code_q;
      low_mask = pend_q & (~pend_q + 20'd1);
      low_idx  = '0;
      for (int unsigned i = 0; i < 20; i++) begin
         if (pend_q[19-i]) low_idx = 5'(19 - i);
      end
      pend_d = pend_q;
      if (valid_q && key_ack) begin
         valid_d = 1'b0;
      end else if (!valid_q && (pend_q != '0)) begin
         code_d  = low_idx;
         pend_d  = pend_q & ~low_mask;
         valid_d = 1'b1;
      end
      // presses accepted this cycle join the mask after the slot has taken its bit
      pend_d = pend_d | new_press;
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         row_q    <= '0;
         settle_q <= '0;
         stable_q <= '0;
         snap_q   <= '0;
         prev_q   <= '0;
         map_q    <= '0;
         pend_q   <= '0;
         k_row_q  <= '1;
         valid_q  <= 1'b0;
         code_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         settle_q <= settle_d;
         stable_q <= stable_d;
         snap_q   <= snap_d;
         prev_q   <= prev_d;
         map_q    <= map_d;
         pend_q   <= pend_d;
         k_row_q  <= k_row_d;
         valid_q  <= valid_d;
         code_q   <= code_d;
         done_q   <= done_d;
      end
   end

   assign K_ROW     = k_row_q;
   assign key_map   = map_q;
   assign key_valid = valid_q;
   assign key_code  = code_q;
   assign scan_done = done_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl with SETTLE_CYC=4, DEBOUNCE_SCANS=3 (21-cycle scan).
// A virtual keypad turns a pressed-key map into column levels for whichever
// row the controller drives; a scan-position reference model is checked every cycle.
module tb_keypad_scan_ctrl;

   localparam int SETTLE = 4;
   localparam int DEB    = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        scan_en;
   logic [3:0]  k_col;
   logic [4:0]  k_row;
   logic [19:0] key_map;
   logic        key_valid;
   logic [4:0]  key_code;
   logic        key_ack;
   logic        scan_done;

   logic [19:0] phys;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int          m_pos;
   logic [19:0] m_snap;
   logic [19:0] m_map;
   logic [19:0] m_pend;
   logic        m_valid;
   logic [4:0]  m_code;
   logic [19:0] hist[$];

   typedef struct {
      logic [19:0] phys;
      logic        ack;
      int          ticks;
      logic [4:0]  e_row;
      logic        e_done;
      logic [19:0] e_map;
      logic        e_valid;
      logic [4:0]  e_code;
   } vec_t;

   vec_t vecs[13];

   keypad_scan_ctrl #(
      .SETTLE_CYC     (SETTLE),
      .DEBOUNCE_SCANS (DEB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .scan_en   (scan_en),
      .K_COL     (k_col),
      .K_ROW     (k_row),
      .key_map   (key_map),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_ack   (key_ack),
      .scan_done (scan_done)
   );

   always #5 clk = ~clk;

   // Virtual keypad: a closed key pulls its column low while its row is driven low.
   always_comb begin
      k_col = 4'hF;
      for (int r = 0; r < 5; r++) begin
         if (!k_row[r]) k_col = k_col & ~phys[r*4 +: 4];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the model over the coming edge using the inputs presented to it.
   task automatic model_edge();
      logic [19:0] newp;
      logic        same;
      int          idx;
      newp = '0;
      if (rst) begin
         m_pos   = -1;
         m_snap  = '0;
         m_map   = '0;
         m_pend  = '0;
         m_valid = 1'b0;
         m_code  = '0;
         hist.delete();
      end else begin
         if (m_pos < 0) begin
            if (scan_en) m_pos = 0;
         end else if (m_pos < 5*SETTLE) begin
            if ((m_pos % SETTLE) == SETTLE-1)
               m_snap[(m_pos/SETTLE)*4 +: 4] = phys[(m_pos/SETTLE)*4 +: 4];
            m_pos++;
         end else begin
            hist.push_back(m_snap);
            if (hist.size() > DEB) void'(hist.pop_front());
            same = (hist.size() == DEB);
            foreach (hist[i]) if (hist[i] !== m_snap) same = 1'b0;
            if (same && (m_snap != m_map)) begin
               newp  = m_snap & ~m_map;
               m_map = m_snap;
            end
            m_pos = scan_en ? 0 : -1;
         end
         if (m_valid && key_ack) begin
            m_valid = 1'b0;
         end else if (!m_valid && (m_pend != 0)) begin
            idx = -1;
            for (int i = 0; i < 20; i++) if (idx < 0 && m_pend[i]) idx = i;
            m_code      = 5'(idx);
            m_pend[idx] = 1'b0;
            m_valid     = 1'b1;
         end
         m_pend = m_pend | newp;
      end
   endtask

   task automatic tick();
      logic [4:0] e_row;
      model_edge();
      @(posedge clk);
      #1;
      e_row = 5'h1F;
      if (m_pos >= 0 && m_pos < 5*SETTLE) e_row = ~(5'b00001 << (m_pos / SETTLE));
      check("model K_ROW",     32'(k_row),     32'(e_row));
      check("model scan_done", 32'(scan_done), 32'(m_pos == 5*SETTLE));
      check("model key_map",   32'(key_map),   32'(m_map));
      check("model key_valid", 32'(key_valid), 32'(m_valid));
      check("model key_code",  32'(key_code),  32'(m_code));
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      scan_en = 1'b1;
      key_ack = 1'b0;
      phys    = '0;
      tick();
      tick();
      check("reset K_ROW",     32'(k_row),     32'h1F);
      check("reset key_map",   32'(key_map),   32'h0);
      check("reset key_valid", 32'(key_valid), 32'h0);
      check("reset key_code",  32'(key_code),  32'h0);
      check("reset scan_done", 32'(scan_done), 32'h0);
      rst = 1'b0;
      tick();
   endtask

   initial begin
      bit saw_valid;

      //            phys       ack ticks row    done map        valid code
      vecs[0]  = '{20'h00000, 0, 20, 5'h1F, 1, 20'h00000, 0, 5'd0};
      vecs[1]  = '{20'h00000, 0, 1,  5'h1E, 0, 20'h00000, 0, 5'd0};
      vecs[2]  = '{20'h00200, 0, 62, 5'h1F, 1, 20'h00000, 0, 5'd0};
      vecs[3]  = '{20'h00200, 0, 1,  5'h1E, 0, 20'h00200, 0, 5'd0};
      vecs[4]  = '{20'h00200, 0, 1,  5'h1E, 0, 20'h00200, 1, 5'd9};
      vecs[5]  = '{20'h00000, 0, 63, 5'h1E, 0, 20'h00000, 1, 5'd9};
      vecs[6]  = '{20'h00000, 1, 1,  5'h1E, 0, 20'h00000, 0, 5'd9};
      vecs[7]  = '{20'h00000, 0, 21, 5'h1E, 0, 20'h00000, 0, 5'd9};
      vecs[8]  = '{20'h20008, 0, 62, 5'h1E, 0, 20'h20008, 1, 5'd3};
      vecs[9]  = '{20'h20008, 1, 1,  5'h1E, 0, 20'h20008, 0, 5'd3};
      vecs[10] = '{20'h20008, 0, 1,  5'h1E, 0, 20'h20008, 1, 5'd17};
      vecs[11] = '{20'h20008, 1, 1,  5'h1D, 0, 20'h20008, 0, 5'd17};
      vecs[12] = '{20'h20008, 0, 3,  5'h1D, 0, 20'h20008, 0, 5'd17};

      // basic scan, single press with hold/release, simultaneous presses
      do_reset();
      foreach (vecs[v]) begin
         phys    = vecs[v].phys;
         key_ack = vecs[v].ack;
         repeat (vecs[v].ticks) tick();
         check($sformatf("vec%0d K_ROW", v),     32'(k_row),     32'(vecs[v].e_row));
         check($sformatf("vec%0d scan_done", v), 32'(scan_done), 32'(vecs[v].e_done));
         check($sformatf("vec%0d key_map", v),   32'(key_map),   32'(vecs[v].e_map));
         check($sformatf("vec%0d key_valid", v), 32'(key_valid), 32'(vecs[v].e_valid));
         check($sformatf("vec%0d key_code", v),  32'(key_code),  32'(vecs[v].e_code));
      end
      key_ack = 1'b0;

      // bouncing key never accepted, then accepted after three stable scans
      do_reset();
      for (int s = 0; s < 10; s++) begin
         phys = (s % 2 == 0) ? 20'h00010 : 20'h00000;
         repeat (21) tick();
         check("bounce key_map",   32'(key_map),   32'h0);
         check("bounce key_valid", 32'(key_valid), 32'h0);
      end
      phys = 20'h00010;
      repeat (21) tick();
      check("stable1 key_map", 32'(key_map), 32'h0);
      repeat (21) tick();
      check("stable2 key_map", 32'(key_map), 32'h0);
      repeat (21) tick();
      check("stable3 key_map", 32'(key_map), 32'h10);
      tick();
      check("stable3 key_valid", 32'(key_valid), 32'h1);
      check("stable3 key_code",  32'(key_code),  32'h4);

      // scan_en dropped during row 1: scan completes, then parks
      do_reset();
      phys = '0;
      repeat (5) tick();
      check("scan_en row1 K_ROW", 32'(k_row), 32'h1D);
      scan_en = 1'b0;
      repeat (15) tick();
      check("scan_en compare scan_done", 32'(scan_done), 32'h1);
      check("scan_en compare K_ROW",     32'(k_row),     32'h1F);
      tick();
      check("scan_en idle K_ROW", 32'(k_row), 32'h1F);
      repeat (5) tick();
      check("scan_en idle hold K_ROW", 32'(k_row),     32'h1F);
      check("scan_en idle scan_done",  32'(scan_done), 32'h0);
      scan_en = 1'b1;
      tick();
      check("scan_en restart K_ROW", 32'(k_row), 32'h1E);
      repeat (4) tick();
      check("scan_en restart row1", 32'(k_row), 32'h1D);

      // reset while one event is shown and two are pending
      do_reset();
      phys = 20'h00422;
      repeat (64) tick();
      check("prerst key_valid", 32'(key_valid), 32'h1);
      check("prerst key_code",  32'(key_code),  32'h1);
      check("prerst key_map",   32'(key_map),   32'h422);
      rst  = 1'b1;
      phys = '0;
      tick();
      check("midrst K_ROW",     32'(k_row),     32'h1F);
      check("midrst key_map",   32'(key_map),   32'h0);
      check("midrst key_valid", 32'(key_valid), 32'h0);
      check("midrst key_code",  32'(key_code),  32'h0);
      check("midrst scan_done", 32'(scan_done), 32'h0);
      rst = 1'b0;
      saw_valid = 1'b0;
      repeat (120) begin
         tick();
         if (key_valid) saw_valid = 1'b1;
      end
      check("postrst stale event", 32'(saw_valid), 32'h0);

      // randomized keys, acks, scan_en toggles and occasional reset
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 119) == 0) begin
            phys = '0;
            repeat ($urandom_range(0, 3)) phys[$urandom_range(0, 19)] = 1'b1;
         end
         key_ack = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 199) == 0) scan_en = ~scan_en;
         rst = ($urandom_range(0, 1499) == 0);
         tick();
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
